// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: two-master round-robin arbiter for the mips_cpu_bus Avalon memory port (ARB_LOCK_EN adds per-master bus lock)
module mips_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_address,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata
);
    typedef enum logic [2:0] {IDLE, GNT0, GNT1, RSP0, RSP1} state_t;
    state_t state;
    logic last, locked, lock0, lock1, req0, req1, gnt0, gnt1;
`ifdef ARB_LOCK_EN
    assign lock0 = m0_lock;
    assign lock1 = m1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif
    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;
    assign gnt0 = state == GNT0;
    assign gnt1 = state == GNT1;
    // Put the granted master on the slave port (write wins over read) and steer read data to its owner
    always_comb begin
        s_read = gnt0 ? m0_read & ~m0_write : gnt1 ? m1_read & ~m1_write : 1'b0;
        s_write = gnt0 ? m0_write : gnt1 ? m1_write : 1'b0;
        s_address = gnt0 ? m0_address : gnt1 ? m1_address : '0;
        s_writedata = gnt0 ? m0_writedata : gnt1 ? m1_writedata : '0;
        s_byteenable = gnt0 ? m0_byteenable : gnt1 ? m1_byteenable : '0;
        m0_waitrequest = gnt0 ? s_waitrequest : 1'b1;
        m1_waitrequest = gnt1 ? s_waitrequest : 1'b1;
        m0_readdatavalid = state == RSP0;
        m1_readdatavalid = state == RSP1;
        m0_readdata = (state == RSP0) ? s_readdata : '0;
        m1_readdata = (state == RSP1) ? s_readdata : '0;
    end
    // Ownership sequencer: one-cycle round-robin arbitration, grant until acceptance, one response cycle for reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last <= 1'b0;
            locked <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= (req0 & (~req1 | last)) ? GNT0 : req1 ? GNT1 : IDLE;
                GNT0: begin
                    if (!req0) begin
                        state <= IDLE;
                        locked <= 1'b0;
                    end else if (!s_waitrequest) begin
                        last <= 1'b0;
                        locked <= lock0;
                        state <= m0_write ? (lock0 ? GNT0 : IDLE) : RSP0;
                    end
                end
                GNT1: begin
                    if (!req1) begin
                        state <= IDLE;
                        locked <= 1'b0;
                    end else if (!s_waitrequest) begin
                        last <= 1'b1;
                        locked <= lock1;
                        state <= m1_write ? (lock1 ? GNT1 : IDLE) : RSP1;
                    end
                end
                RSP0: state <= locked ? GNT0 : IDLE;
                RSP1: state <= locked ? GNT1 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed vectors, corner sequences and a randomized scoreboard run for mips_bus_arbiter
module tb_mips_bus_arbiter;
    localparam logic [31:0] A0 = 32'hBFC00000, A1 = 32'hBFC00010, D0 = 32'h12345678, D1 = 32'hDEADBEEF;
    logic clk = 1'b0, reset = 1'b1;
    logic m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0, s_waitrequest = 0;
    logic [31:0] m0_address = 0, m0_writedata = 0, m1_address = 0, m1_writedata = 0, s_readdata = 0;
    logic [3:0] m0_byteenable = 0, m1_byteenable = 0;
    logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, s_read, s_write;
    logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
    logic [3:0] s_byteenable;
`ifdef ARB_LOCK_EN
    logic m0_lock = 0, m1_lock = 0;
`endif
    int compared = 0, mismatched = 0;

    mips_bus_arbiter dut (
        .clk(clk), .reset(reset),
`ifdef ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic r0, w0, r1, w1, sw;
        logic [31:0] srd;
        logic [137:0] exp;
    } vec_t;
    vec_t tbl [14];

    function automatic logic [137:0] outs();
        return {s_read, s_write, s_address, s_writedata, s_byteenable, m0_waitrequest, m1_waitrequest,
                m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata};
    endfunction

    function automatic logic [137:0] eo(logic rd, logic wr, logic [31:0] a, logic [31:0] wd, logic [3:0] be,
                                        logic w0, logic w1, logic v0, logic v1, logic [31:0] d0, logic [31:0] d1);
        return {rd, wr, a, wd, be, w0, w1, v0, v1, d0, d1};
    endfunction

    function automatic vec_t mk(logic r0, logic w0, logic r1, logic w1, logic sw, logic [31:0] srd, logic [137:0] e);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.sw = sw; v.srd = srd; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [137:0] act, input logic [137:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        {m0_read, m0_write, m1_read, m1_write, s_waitrequest} = '0;
`ifdef ARB_LOCK_EN
        {m0_lock, m1_lock} = '0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // behavioural reference: cycle numbers of the next arbitration and response, plus round-robin memory
    logic [31:0] mem [16];
    int cyc, nxt_arb, win, rsp_m, rsp_cyc;
    logic m_last;
    logic [31:0] rsp_data;

    task automatic model_check();
        logic rr, ww, e_rd, e_wr, e_w0, e_w1, e_v0, e_v1, q0, q1;
        logic [31:0] e_a, e_wd, e_d0, e_d1;
        logic [3:0] e_be;
        {e_rd, e_wr, e_a, e_wd, e_be, e_v0, e_v1, e_d0, e_d1} = '0;
        e_w0 = 1'b1;
        e_w1 = 1'b1;
        if (rsp_m >= 0 && rsp_cyc == cyc) begin
            if (rsp_m == 0) begin e_v0 = 1'b1; e_d0 = rsp_data; end
            else begin e_v1 = 1'b1; e_d1 = rsp_data; end
            rsp_m = -1;
        end
        if (win >= 0) begin
            rr = (win == 1) ? m1_read : m0_read;
            ww = (win == 1) ? m1_write : m0_write;
            e_rd = rr & ~ww;
            e_wr = ww;
            e_a = (win == 1) ? m1_address : m0_address;
            e_wd = (win == 1) ? m1_writedata : m0_writedata;
            e_be = (win == 1) ? m1_byteenable : m0_byteenable;
            if (win == 1) e_w1 = s_waitrequest; else e_w0 = s_waitrequest;
            if (!(rr | ww)) begin
                win = -1;
                nxt_arb = cyc + 1;
            end else if (!s_waitrequest) begin
                m_last = (win == 1);
                if (ww) nxt_arb = cyc + 1;
                else begin
                    rsp_m = win;
                    rsp_cyc = cyc + 1;
                    rsp_data = mem[e_a[5:2]];
                    nxt_arb = cyc + 2;
                end
                win = -1;
            end
        end else if (cyc == nxt_arb) begin
            q0 = m0_read | m0_write;
            q1 = m1_read | m1_write;
            if (q0 && q1) win = m_last ? 0 : 1;
            else if (q0) win = 0;
            else if (q1) win = 1;
            else nxt_arb = cyc + 1;
        end
        check($sformatf("rand_cyc%0d", cyc), outs(), eo(e_rd, e_wr, e_a, e_wd, e_be, e_w0, e_w1, e_v0, e_v1, e_d0, e_d1));
        cyc++;
    endtask

    initial begin
        logic [137:0] idle_o;
        logic [11:0] g0, g1, v0, v1;
        logic busy [2];
        logic done [2];
        logic rd_pend;
        logic [3:0] rd_idx;
        idle_o = eo(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[0]  = mk(0, 0, 0, 1, 0, 32'h0, idle_o);
        tbl[1]  = mk(0, 0, 0, 1, 0, 32'h0, eo(0, 1, A1, D1, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl[2]  = mk(1, 0, 0, 0, 0, 32'h0, idle_o);
        tbl[3]  = mk(1, 0, 0, 0, 0, 32'h0, eo(1, 0, A0, D0, 4'h3, 0, 1, 0, 0, 0, 0));
        tbl[4]  = mk(0, 0, 0, 0, 0, 32'h3C02FFFF, eo(0, 0, 0, 0, 0, 1, 1, 1, 0, 32'h3C02FFFF, 0));
        tbl[5]  = mk(0, 0, 0, 0, 0, 32'h3C02FFFF, idle_o);
        tbl[6]  = mk(0, 1, 0, 0, 0, 32'h0, idle_o);
        tbl[7]  = mk(0, 1, 0, 1, 1, 32'h0, eo(0, 1, A0, D0, 4'h3, 1, 1, 0, 0, 0, 0));
        tbl[8]  = mk(0, 1, 0, 1, 1, 32'h0, eo(0, 1, A0, D0, 4'h3, 1, 1, 0, 0, 0, 0));
        tbl[9]  = mk(0, 1, 0, 1, 1, 32'h0, eo(0, 1, A0, D0, 4'h3, 1, 1, 0, 0, 0, 0));
        tbl[10] = mk(0, 1, 0, 1, 0, 32'h0, eo(0, 1, A0, D0, 4'h3, 0, 1, 0, 0, 0, 0));
        tbl[11] = mk(0, 0, 0, 1, 0, 32'h0, idle_o);
        tbl[12] = mk(0, 0, 0, 1, 0, 32'h0, eo(0, 1, A1, D1, 4'hF, 1, 0, 0, 0, 0, 0));
        tbl[13] = mk(0, 0, 0, 0, 0, 32'h0, idle_o);

        m0_address = A0; m0_writedata = D0; m0_byteenable = 4'h3;
        m1_address = A1; m1_writedata = D1; m1_byteenable = 4'hF;
        m0_write = 1'b1; m1_read = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_state", outs(), idle_o);
        clear_inputs();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            {m0_read, m0_write, m1_read, m1_write, s_waitrequest} = {tbl[i].r0, tbl[i].w0, tbl[i].r1, tbl[i].w1, tbl[i].sw};
            s_readdata = tbl[i].srd;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
            @(posedge clk);
            #1;
        end

        m1_read = 1'b1; s_waitrequest = 1'b1;
        @(posedge clk);
        #3 check("gnt1_stall", 138'({s_read, m1_waitrequest, m0_waitrequest}), 138'(3'b111));
        reset = 1'b1;
        #1 check("async_reset", outs(), idle_o);
        @(posedge clk);
        #1 reset = 1'b0;
        {m0_read, m1_read, s_waitrequest} = '0;
        m0_write = 1'b1; m1_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_tie", 138'({m0_waitrequest, m1_waitrequest, s_address}), 138'({1'b1, 1'b0, A1}));
        @(posedge clk);
        #1 do_reset();

        m0_read = 1'b1; m1_read = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_readdata = 32'hA0000000 + i;
            @(negedge clk);
            g0[i] = !m0_waitrequest; g1[i] = !m1_waitrequest;
            v0[i] = m0_readdatavalid; v1[i] = m1_readdatavalid;
            @(posedge clk);
            #1;
        end
        check("rr_grants", 138'({g1, g0}), 138'({12'h082, 12'h410}));
        check("rr_valids", 138'({v1, v0}), 138'({12'h104, 12'h820}));
        do_reset();

`ifdef ARB_LOCK_EN
        for (int i = 0; i < 6; i++) begin
            m1_write = i >= 1;
            m0_write = i <= 3;
            m0_lock = i <= 2;
            m0_address = A0 + 4 * i;
            @(negedge clk);
            g0[i] = !m0_waitrequest; g1[i] = !m1_waitrequest;
            @(posedge clk);
            #1;
        end
        check("lock_grants", 138'({g1[5:0], g0[5:0]}), 138'({6'b100000, 6'b001110}));
        do_reset();
`endif

        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        cyc = 0; nxt_arb = 0; win = -1; rsp_m = -1; m_last = 1'b0;
        busy[0] = 0; busy[1] = 0; done[0] = 0; done[1] = 0; rd_pend = 0; rd_idx = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (done[m] || !busy[m]) begin
                    int k;
                    logic r, w;
                    k = $urandom_range(0, 5);
                    r = (k <= 1) || (k == 3);
                    w = (k >= 2) && (k <= 3);
                    busy[m] = r | w;
                    if (m == 0) begin
                        m0_read = r; m0_write = w; m0_address = $urandom;
                        m0_writedata = $urandom; m0_byteenable = 4'($urandom);
                    end else begin
                        m1_read = r; m1_write = w; m1_address = $urandom;
                        m1_writedata = $urandom; m1_byteenable = 4'($urandom);
                    end
                end
            end
            s_waitrequest = $urandom_range(0, 2) == 0;
            s_readdata = rd_pend ? mem[rd_idx] : $urandom;
            rd_pend = 1'b0;
            @(negedge clk);
            model_check();
            done[0] = busy[0] && !m0_waitrequest;
            done[1] = busy[1] && !m1_waitrequest;
            if (s_read && !s_waitrequest) begin
                rd_pend = 1'b1;
                rd_idx = s_address[5:2];
            end
            if (s_write && !s_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (s_byteenable[b]) mem[s_address[5:2]][8*b +: 8] = s_writedata[8*b +: 8];
            @(posedge clk);
            #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
